fp_mul_add_core: RTL and testbench

FP_MUL_ADD_CORE -- requirements
Module: fp_mul_add_core

---
 rtl/fp_mul_add_core.sv | 176 +++++++++++++++++
 tb/tb_fp_mul_add_core.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fp_mul_add_core.sv
// fp_mul_add_core: sequenced binary32 multiply then add, result = round(round(a*b) + b)
module fp_mul_add_core #(
    parameter int DATA_WIDTH    = 32,
    parameter int MUL_LATENCY   = 5,
    parameter int ADD_LATENCY   = 7,
    parameter int COUNTER_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  clk_en,
    input  logic [DATA_WIDTH-1:0] dataa,
    input  logic [DATA_WIDTH-1:0] datab,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [COUNTER_WIDTH-1:0] MUL_CNT = COUNTER_WIDTH'(MUL_LATENCY);
    localparam logic [COUNTER_WIDTH-1:0] ADD_CNT = COUNTER_WIDTH'(ADD_LATENCY);
    localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE, STARTING, WAITING_MUL, START_ADD, WAITING_ADD, DONE
    } state_t;

    state_t                   state_q;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0]    a_q, b_q, prod_q, result_q;
    logic                     done_q;
    logic [31:0]              prod_d, sum_d;

    // Multiply with flush-to-zero on inputs and outputs, round to nearest even.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
        logic [47:0]        p;
        logic signed [9:0]  e;
        logic [22:0]        m;
        logic [23:0]        r;
        logic [31:0]        y;
        s      = a[31] ^ b[31];
        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        a_zero = ~|a[30:23];
        b_zero = ~|b[30:23];
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m  = p[46:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = p[45:23];
            g  = p[22];
            st = |p[21:0];
        end
        r = {1'b0, m} + {23'b0, g & (st | m[0])};
        if (r[23]) e = e + 10'sd1;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) y = QNAN;
        else if (a_inf || b_inf) y = {s, 8'hFF, 23'b0};
        else if (a_zero || b_zero) y = {s, 31'b0};
        else if (e >= 10'sd255) y = {s, 8'hFF, 23'b0};
        else if (e <= 10'sd0) y = {s, 31'b0};
        else y = {s, e[7:0], r[22:0]};
        return y;
    endfunction

    // Add with flush-to-zero, round to nearest even; guard/round/sticky carried in 3 extra bits.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0]       big, sml, y;
        logic [7:0]        d;
        logic [26:0]       bs, ss, sh;
        logic [27:0]       sum;
        logic [26:0]       n;
        logic [4:0]        msb, lz;
        logic signed [9:0] e;
        logic [23:0]       r;
        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        a_zero = ~|a[30:23];
        b_zero = ~|b[30:23];
        big = (b[30:0] > a[30:0]) ? b : a;
        sml = (b[30:0] > a[30:0]) ? a : b;
        d   = big[30:23] - sml[30:23];
        bs  = {1'b1, big[22:0], 3'b0};
        ss  = {1'b1, sml[22:0], 3'b0};
        if (d > 8'd26) begin
            sh = 27'd1;
        end else begin
            sh    = ss >> d;
            sh[0] = sh[0] | (|(ss & ~(27'h7FF_FFFF << d)));
        end
        sum = (big[31] == sml[31]) ? {1'b0, bs} + {1'b0, sh} : {1'b0, bs} - {1'b0, sh};
        e   = $signed({2'b0, big[30:23]});
        msb = 5'd0;
        for (int i = 0; i < 27; i++) if (sum[i]) msb = i[4:0];
        lz  = 5'd26 - msb;
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
        end else begin
            n = sum[26:0] << lz;
            e = e - $signed({5'b0, lz});
        end
        r = {1'b0, n[25:3]} + {23'b0, n[2] & (n[3] | n[1] | n[0])};
        if (r[23]) e = e + 10'sd1;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31]))) y = QNAN;
        else if (a_inf) y = {a[31], 8'hFF, 23'b0};
        else if (b_inf) y = {b[31], 8'hFF, 23'b0};
        else if (a_zero && b_zero) y = {a[31] & b[31], 31'b0};
        else if (a_zero) y = b;
        else if (b_zero) y = a;
        else if (sum == 28'd0) y = 32'h0000_0000;
        else if (e >= 10'sd255) y = {big[31], 8'hFF, 23'b0};
        else if (e <= 10'sd0) y = {big[31], 31'b0};
        else y = {big[31], e[7:0], r[22:0]};
        return y;
    endfunction

    assign prod_d = fp_mul(a_q, b_q);
    assign sum_d  = fp_add(prod_q, b_q);

    // Phase sequencer: latch operands, time each phase with the delay counter, register results.
    always_ff @(posedge clock) begin
        if (aclr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (clk_en) begin
                    state_q <= STARTING;
                    a_q     <= dataa;
                    b_q     <= datab;
                end
                STARTING: begin
                    state_q <= WAITING_MUL;
                    cnt_q   <= MUL_CNT;
                end
                WAITING_MUL: if (cnt_q == ONE) begin
                    state_q <= START_ADD;
                    cnt_q   <= '0;
                    prod_q  <= prod_d;
                end else begin
                    cnt_q <= cnt_q - ONE;
                end
                START_ADD: begin
                    state_q <= WAITING_ADD;
                    cnt_q   <= ADD_CNT;
                end
                WAITING_ADD: if (cnt_q == ONE) begin
                    state_q  <= DONE;
                    cnt_q    <= '0;
                    result_q <= sum_d;
                    done_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - ONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
endmodule

// File: tb/tb_fp_mul_add_core.sv
// tb_fp_mul_add_core: scoreboard bench for the sequenced multiply-add core
module tb_fp_mul_add_core;
    localparam int LAT = 14;

    logic        clock, aclr, clk_en, done;
    logic [31:0] dataa, datab, result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] vec [14][3] = '{
        '{32'h40000000, 32'h40400000, 32'h41100000},
        '{32'h3FC00000, 32'hC0000000, 32'hC0A00000},
        '{32'h00000000, 32'h3F800000, 32'h3F800000},
        '{32'h7F800000, 32'h00000000, 32'h7FC00000},
        '{32'h7FC00000, 32'h3F800000, 32'h7FC00000},
        '{32'h3F800000, 32'h3F800000, 32'h40000000},
        '{32'hBF800000, 32'h3F800000, 32'h00000000},
        '{32'h00000000, 32'h80000000, 32'h80000000},
        '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000},
        '{32'h3F800000, 32'h7F7FFFFF, 32'h7F800000},
        '{32'hFF800000, 32'h7F800000, 32'h7FC00000},
        '{32'h3F800001, 32'h3F800001, 32'h40000002},
        '{32'hBF400000, 32'h00800000, 32'h00800000},
        '{32'h3F800000, 32'h00400000, 32'h00000000}
    };

    fp_mul_add_core dut (
        .clock (clock),
        .aclr  (aclr),
        .clk_en(clk_en),
        .dataa (dataa),
        .datab (datab),
        .result(result),
        .done  (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done cycle must match the oldest expected completion in value and timing.
    always @(negedge clock) begin
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("result", result, mon_e.res);
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        @(negedge clock);
        dataa  = a;
        datab  = b;
        clk_en = 1'b1;
        q.push_back('{e, cyc + 1 + LAT});
        @(negedge clock);
        clk_en = 1'b0;
        dataa  = $urandom;
        datab  = $urandom;
        repeat (18) @(negedge clock);
    endtask

    initial begin
        int s;
        aclr   = 1'b1;
        clk_en = 1'b0;
        dataa  = '0;
        datab  = '0;
        repeat (3) @(negedge clock);
        chk("reset_result", result, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        aclr = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 14; i++) run(vec[i][0], vec[i][1], vec[i][2]);
        chk("result_hold", result, 32'h00000000);
        @(negedge clock);
        dataa  = 32'h40000000;
        datab  = 32'h40400000;
        clk_en = 1'b1;
        s = cyc + 1;
        for (int k = 0; k < 3; k++) q.push_back('{32'h41100000, s + LAT + 16 * k});
        repeat (47) @(negedge clock);
        clk_en = 1'b0;
        repeat (18) @(negedge clock);
        dataa  = 32'h3FC00000;
        datab  = 32'hC0000000;
        clk_en = 1'b1;
        q.push_back('{32'hC0A00000, cyc + 1 + LAT});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            clk_en = k[0];
            dataa  = $urandom;
            datab  = $urandom;
        end
        clk_en = 1'b0;
        repeat (10) @(negedge clock);
        dataa  = 32'h40000000;
        datab  = 32'h40400000;
        clk_en = 1'b1;
        @(negedge clock);
        clk_en = 1'b0;
        repeat (5) @(negedge clock);
        aclr = 1'b1;
        @(negedge clock);
        aclr = 1'b0;
        chk("abort_result", result, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        dataa  = 32'h3F800000;
        datab  = 32'h3F800000;
        clk_en = 1'b1;
        q.push_back('{32'h40000000, cyc + 1 + LAT});
        @(negedge clock);
        clk_en = 1'b0;
        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clock);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        repeat (20) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
